key_debounce_fsm: RTL and testbench
===================================

// Module: key_debounce_fsm
// PURPOSE
//  Debounces one mechanical push-button and turns it into clean control events for the LED running-light controller.
//  Sits directly upstream of that controller, one instance per key (stop, left, right).
//  Outputs a debounced level, one-cycle press and release pulses, and a press-toggled latch.
//  The latch gives the stop/run key a run/stop state without any extra logic downstream.
// PARAMETERS
//  DEB_CNT     20'd1_000_000   stable-time cycles needed to accept an edge (20 ms @ 50 MHz)
//  LONG_CNT    30'd100_000_000 held cycles before long-press event (2 s @ 50 MHz), used only with macro
//  KEY_ACTIVE  1'b0            pin level meaning "pressed" (board keys are active-low)
// PORTS
//  clk          input   1  system clock, 50 MHz
//  rst_n        input   1  asynchronous active-low reset
//  key          input   1  raw asynchronous button pin
//  key_level    output  1  debounced state, 1 = pressed
//  key_press    output  1  one-cycle pulse on accepted press
//  key_release  output  1  one-cycle pulse on accepted release
//  key_toggle   output  1  flips on every key_press (run/stop latch)
//  key_long     output  1  one-cycle pulse on long press (0 when feature compiled out)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counter 0, synchroniser flops = ~KEY_ACTIVE (released).
//  - key passes through a 2-flop synchroniser -> key_s. pressed = (key_s == KEY_ACTIVE). No combinational path from key.
//  - FSM states IDLE, PRESS_DEB, HELD, REL_DEB; single counter cnt, clears on every state change.
//  - IDLE:
//      pressed -> PRESS_DEB, cnt=0.
//  - PRESS_DEB:
//      !pressed (bounce) -> IDLE, no outputs.
//      cnt==DEB_CNT-1 -> HELD; key_press=1, key_level<=1, key_toggle<=~key_toggle.
//      otherwise cnt++.
//  - HELD:
//      !pressed -> REL_DEB, cnt=0.
//      otherwise cnt++, saturating at LONG_CNT-1.
//  - REL_DEB:
//      pressed (bounce) -> HELD, no outputs; long-press count restarts from 0.
//      cnt==DEB_CNT-1 -> IDLE; key_release=1, key_level<=0.
//      otherwise cnt++.
//  - Latency: with a clean edge, key_press is high on the DEB_CNT+3rd rising edge after the pin first shows the
//    pressed level: 2 synchroniser edges + 1 IDLE edge + DEB_CNT. key_release has the same latency.
//  - Pulses are registered and exactly 1 cycle wide. key_press and key_release are never high together.
//    At most one press pulse per press/release pair.
//  - Glitches shorter than DEB_CNT cycles produce no event in either direction.
//  - Reset mid-debounce or mid-hold: immediate return to reset values. The key still held after reset
//    re-debounces and yields a fresh key_press.
//  - Counter width = max(width(DEB_CNT), width(LONG_CNT)). It never wraps.
// CONFIGURATION
//  - KEY_LONG_PRESS_EN defined:
//      in HELD, when cnt reaches LONG_CNT-1, key_long pulses for 1 cycle.
//      Fires once per hold; no auto-repeat until release is accepted.
//  - KEY_LONG_PRESS_EN undefined:
//      key_long tied 0, HELD counter logic removed. All other behaviour unchanged.
// TESTING (bench uses DEB_CNT=8, LONG_CNT=32, KEY_ACTIVE=0)
//  1. Reset, key=1 held -> all outputs 0 for 100 cycles.
//  2. key 1->0 clean at edge 0 -> key_press=1 on edge 11 only, key_level=1 from then, key_toggle=1.
//  3. Bounce: key=0 for 5 cycles then 1, repeated 4x -> no key_press, key_level stays 0.
//  4. Press 20 cycles, then release clean -> key_release pulse 11 edges after release.
//     Second full press/release -> key_toggle back to 0.
//  5. KEY_LONG_PRESS_EN: hold 60 cycles past key_press -> exactly one key_long, 32 edges after key_press.
//     Macro off -> key_long always 0.
//  6. Assert rst_n low during PRESS_DEB (cnt=4) with key held -> outputs 0.
//     After release of reset -> key_press 11 edges later.

Source files
------------

// File: rtl/key_debounce_fsm_if.sv
// Key event bundle between a debounced push-button and its consumer.
// master drives the raw pin and consumes events; slave is the debouncer.
interface key_debounce_fsm_if;
    logic key;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_toggle;
    logic key_long;

    modport master (
        output key,
        input  key_level, key_press, key_release, key_toggle, key_long
    );

    modport slave (
        input  key,
        output key_level, key_press, key_release, key_toggle, key_long
    );
endinterface

// File: rtl/key_debounce_fsm.sv
// Push-button debouncer: level, press/release pulses and a run/stop toggle latch.
// Optional long-press pulse is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce_fsm #(
    parameter logic [19:0] DEB_CNT    = 20'd1_000_000,
    parameter logic [29:0] LONG_CNT   = 30'd100_000_000,
    parameter logic        KEY_ACTIVE = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    key_debounce_fsm_if.slave bus
);

    localparam int CW = ($bits(DEB_CNT) > $bits(LONG_CNT)) ? $bits(DEB_CNT) : $bits(LONG_CNT);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t DEB_LAST  = cnt_t'(DEB_CNT) - cnt_t'(1);
`ifdef KEY_LONG_PRESS_EN
    localparam cnt_t LONG_LAST = cnt_t'(LONG_CNT) - cnt_t'(1);
`endif

    typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} state_t;

    state_t state, state_n;
    cnt_t   cnt, cnt_n;
    logic   sync1, key_s, pressed;
    logic   level_q, level_n, toggle_q, toggle_n;
    logic   press_q, press_n, release_q, release_n;
`ifdef KEY_LONG_PRESS_EN
    logic   long_q, long_n, long_done, long_done_n;
`endif

    // NOTE: synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= ~KEY_ACTIVE;
            key_s <= ~KEY_ACTIVE;
        end else begin
            sync1 <= bus.key;
            key_s <= sync1;
        end
    end

    assign pressed = (key_s == KEY_ACTIVE);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        level_n   = level_q;
        toggle_n  = toggle_q;
        press_n   = 1'b0;
        release_n = 1'b0;
`ifdef KEY_LONG_PRESS_EN
        long_n      = 1'b0;
        long_done_n = long_done;
`endif
        unique case (state)
            IDLE: begin
                if (pressed) begin
                    state_n = PRESS_DEB;
                    cnt_n   = '0;
                end
            end
            PRESS_DEB: begin
                if (!pressed) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n  = HELD;
                    cnt_n    = '0;
                    press_n  = 1'b1;
                    level_n  = 1'b1;
                    toggle_n = ~toggle_q;
                end else begin
                    cnt_n = cnt + cnt_t'(1);
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_n = REL_DEB;
                    cnt_n   = '0;
                end else begin
`ifdef KEY_LONG_PRESS_EN
                    // Saturate at the threshold; long_done suppresses repeats until release.
                    if (cnt != LONG_LAST) begin
                        cnt_n = cnt + cnt_t'(1);
                    end else if (!long_done) begin
                        long_n      = 1'b1;
                        long_done_n = 1'b1;
                    end
`endif
                end
            end
            REL_DEB: begin
                if (pressed) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    release_n = 1'b1;
                    level_n   = 1'b0;
`ifdef KEY_LONG_PRESS_EN
                    long_done_n = 1'b0;
`endif
                end else begin
                    cnt_n = cnt + cnt_t'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            level_q   <= 1'b0;
            toggle_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            long_q    <= 1'b0;
            long_done <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            level_q   <= level_n;
            toggle_q  <= toggle_n;
            press_q   <= press_n;
            release_q <= release_n;
`ifdef KEY_LONG_PRESS_EN
            long_q    <= long_n;
            long_done <= long_done_n;
`endif
        end
    end

    assign bus.key_level   = level_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;
    assign bus.key_toggle  = toggle_q;
`ifdef KEY_LONG_PRESS_EN
    assign bus.key_long    = long_q;
`else
    assign bus.key_long    = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_fsm.sv
// Bench for key_debounce_fsm: directed scenarios plus random pin activity against a run-length model.
// Long-press expectations follow KEY_LONG_PRESS_EN.
module tb_key_debounce_fsm;

    localparam int D = 8;
    localparam int L = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_debounce_fsm_if bus();

    key_debounce_fsm #(
        .DEB_CNT    (20'd8),
        .LONG_CNT   (30'd32),
        .KEY_ACTIVE (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int edge_no = 0;

    // Reference model: the pin is seen two edges late; the debounced level flips once the
    // seen value has disagreed with it for D+1 consecutive edges.
    bit pin_q[$];
    bit m_level, m_toggle, m_press, m_rel, m_long, m_prev, m_fired;
    int m_run, m_hold;

    int press_cnt, rel_cnt, long_cnt;
    int last_press_edge, last_rel_edge, last_long_edge;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, edge_no);
        end
    endtask

    task automatic model_reset();
        pin_q = '{1'b1, 1'b1};
        m_level = 0; m_toggle = 0; m_press = 0; m_rel = 0; m_long = 0;
        m_prev = 0; m_fired = 0; m_run = 0; m_hold = 0;
    endtask

    task automatic model_edge(input bit p);
        bit pr;
        pr = (pin_q.pop_front() == 1'b0);
        pin_q.push_back(p);
        m_press = 0; m_rel = 0; m_long = 0;
        if (pr != m_level) m_run++;
        else m_run = 0;
        if (m_run == D + 1) begin
            m_run = 0;
            m_level = pr;
            if (pr) begin
                m_press = 1;
                m_toggle = ~m_toggle;
                m_hold = 0;
            end else begin
                m_rel = 1;
                m_fired = 0;
            end
        end else if (m_level && pr) begin
            if (!m_prev) m_hold = 0;
            else if (m_hold < L) m_hold++;
`ifdef KEY_LONG_PRESS_EN
            if (m_hold == L && !m_fired) begin
                m_long = 1;
                m_fired = 1;
            end
`endif
        end
        m_prev = pr;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_level"},   bus.key_level,   0);
        check({tag, "_press"},   bus.key_press,   0);
        check({tag, "_release"}, bus.key_release, 0);
        check({tag, "_toggle"},  bus.key_toggle,  0);
        check({tag, "_long"},    bus.key_long,    0);
    endtask

    task automatic step(input bit p);
        bus.key = p;
        @(posedge clk);
        edge_no++;
        model_edge(p);
        #1;
        check("level",   bus.key_level,   m_level);
        check("press",   bus.key_press,   m_press);
        check("release", bus.key_release, m_rel);
        check("toggle",  bus.key_toggle,  m_toggle);
        check("long",    bus.key_long,    m_long);
        if (bus.key_press === 1'b1)   begin press_cnt++; last_press_edge = edge_no; end
        if (bus.key_release === 1'b1) begin rel_cnt++;   last_rel_edge   = edge_no; end
        if (bus.key_long === 1'b1)    begin long_cnt++;  last_long_edge  = edge_no; end
    endtask

    task automatic hold(input bit p, input int n);
        for (int i = 0; i < n; i++) step(p);
    endtask

    initial begin
        int t0;
        int pe;
        bus.key = 1'b1;
        rst_n = 1'b0;
        model_reset();
        press_cnt = 0; rel_cnt = 0; long_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Released key: nothing happens for 100 cycles.
        hold(1'b1, 100);
        check("idle_press_cnt", press_cnt, 0);

        // Clean press: pulse exactly 11 edges after the pin changes.
        t0 = edge_no;
        hold(1'b0, 15);
        check("press_cnt", press_cnt, 1);
        check("press_edge", last_press_edge, t0 + 11);
        check("press_toggle", bus.key_toggle, 1);
        check("press_level", bus.key_level, 1);
        hold(1'b0, 10);

        // Clean release after a ~20 cycle hold.
        t0 = edge_no;
        hold(1'b1, 15);
        check("rel_cnt", rel_cnt, 1);
        check("rel_edge", last_rel_edge, t0 + 11);

        // Second full press/release returns the toggle to 0.
        hold(1'b0, 20);
        hold(1'b1, 20);
        check("press_cnt2", press_cnt, 2);
        check("toggle_back", bus.key_toggle, 0);

        // Bounces shorter than the debounce window.
        press_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            hold(1'b0, 5);
            hold(1'b1, 5);
        end
        hold(1'b1, 12);
        check("bounce_press_cnt", press_cnt, 0);
        check("bounce_level", bus.key_level, 0);

        // Long hold: 60 cycles past the press pulse.
        long_cnt = 0;
        t0 = edge_no;
        hold(1'b0, 11);
        check("long_press_edge", last_press_edge, t0 + 11);
        pe = last_press_edge;
        hold(1'b0, 60);
`ifdef KEY_LONG_PRESS_EN
        check("long_cnt", long_cnt, 1);
        check("long_edge", last_long_edge, pe + 32);
`else
        check("long_cnt", long_cnt, 0);
`endif
        hold(1'b1, 15);

        // Reset in the middle of press debounce with the key held.
        t0 = edge_no;
        hold(1'b0, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        model_reset();
        press_cnt = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        t0 = edge_no;
        hold(1'b0, 15);
        check("rearm_press_cnt", press_cnt, 1);
        check("rearm_press_edge", last_press_edge, t0 + 11);
        hold(1'b1, 15);

        // Random pin activity: mixed glitches and genuine presses.
        for (int i = 0; i < 60; i++) begin
            bit p;
            int n;
            p = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 24);
            hold(p, n);
        end
        hold(1'b1, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
